// File: rtl/uart_host_bridge.sv
// uart_host_bridge: turns a valid/ready TX byte stream into CoreUART host write cycles and polls RXRDY for reads.
// Received bytes are held in a single-entry register with their error tags until the client takes them.
module uart_host_bridge #(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter bit          RD_PRIORITY   = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic [1:0] rx_err,
  input  logic       rx_ready,
  output logic       ovf_flag,
  input  logic       ovf_clr,
  output logic       UART_CSN,
  output logic       UART_WEN,
  output logic       UART_OEN,
  output logic [7:0] UART_WDATA,
  input  logic [7:0] UART_RDATA,
  input  logic       UART_TXRDY,
  input  logic       UART_RXRDY,
  input  logic       UART_PERR,
  input  logic       UART_FERR,
  input  logic       UART_OVF
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, SETTLE} state_t;
  state_t     r_state;
  logic [3:0] r_cnt;
  logic       w_rd_ok, w_wr_ok, w_rd_go, w_wr_go;
  assign w_rd_ok  = UART_RXRDY & ~rx_valid;
  assign w_wr_ok  = tx_valid & UART_TXRDY;
  assign w_rd_go  = (r_state == IDLE) & w_rd_ok & (RD_PRIORITY | ~w_wr_ok);
  assign w_wr_go  = (r_state == IDLE) & w_wr_ok & ~w_rd_go;
  assign tx_ready = w_wr_go & ~RESET;
  // strobes are registered from the access decision so they line up exactly with WRITE/READ
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      UART_CSN   <= 1'b1;
      UART_WEN   <= 1'b1;
      UART_OEN   <= 1'b1;
      UART_WDATA <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_err     <= '0;
      ovf_flag   <= 1'b0;
    end else begin
      UART_CSN <= ~(w_wr_go | w_rd_go);
      UART_WEN <= ~w_wr_go;
      UART_OEN <= ~w_rd_go;
      ovf_flag <= UART_OVF | (ovf_flag & ~ovf_clr);
      if (w_wr_go) UART_WDATA <= tx_data;
      if (rx_valid & rx_ready) rx_valid <= 1'b0;
      case (r_state)
        IDLE: r_state <= w_rd_go ? READ : w_wr_go ? WRITE : IDLE;
        WRITE: begin
          r_state <= SETTLE;
          r_cnt   <= 4'(SETTLE_CYCLES);
        end
        READ: begin
          rx_data  <= UART_RDATA;
          rx_err   <= {UART_FERR, UART_PERR};
          rx_valid <= 1'b1;
          r_state  <= SETTLE;
          r_cnt    <= 4'(SETTLE_CYCLES);
        end
        default: begin
          r_cnt   <= r_cnt - 4'd1;
          r_state <= (r_cnt == 4'd1) ? IDLE : SETTLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_host_bridge.sv
// tb_uart_host_bridge: scoreboard bench for uart_host_bridge; a second instance with write priority
// shares all inputs except tx_valid.
`timescale 1ns/1ps
module tb_uart_host_bridge;
  typedef struct {bit wr; logic [7:0] d; logic [1:0] e;} acc_t;
  logic       clk = 1'b0, rst = 1'b1;
  logic       tx_valid = 1'b0, tx_valid0 = 1'b0, rx_ready = 1'b0, ovf_clr = 1'b0;
  logic [7:0] tx_data = 8'h00, rdata = 8'h00;
  logic       txrdy = 1'b0, rxrdy = 1'b0, perr = 1'b0, ferr = 1'b0, ovf = 1'b0;
  logic       tx_ready, rx_valid, ovf_flag, csn, wen, oen;
  logic [7:0] rx_data, wdata;
  logic [1:0] rx_err;
  logic       tx_ready_0, rx_valid_0, ovf_flag_0, csn_0, wen_0, oen_0;
  logic [7:0] rx_data_0, wdata_0;
  logic [1:0] rx_err_0;
  int   total = 0, bad = 0;
  acc_t exp_q[$], exp_q0[$];
  acc_t pend, pend0;
  bit   rd_pend = 0, rd_pend0 = 0, mon0 = 0, seen = 0, seen0 = 0;

  uart_host_bridge #(.SETTLE_CYCLES(3), .RD_PRIORITY(1'b1)) dut (
    .CLK(clk), .RESET(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .rx_ready(rx_ready),
    .ovf_flag(ovf_flag), .ovf_clr(ovf_clr), .UART_CSN(csn), .UART_WEN(wen), .UART_OEN(oen),
    .UART_WDATA(wdata), .UART_RDATA(rdata), .UART_TXRDY(txrdy), .UART_RXRDY(rxrdy),
    .UART_PERR(perr), .UART_FERR(ferr), .UART_OVF(ovf));

  uart_host_bridge #(.SETTLE_CYCLES(3), .RD_PRIORITY(1'b0)) dut0 (
    .CLK(clk), .RESET(rst), .tx_valid(tx_valid0), .tx_data(tx_data), .tx_ready(tx_ready_0),
    .rx_valid(rx_valid_0), .rx_data(rx_data_0), .rx_err(rx_err_0), .rx_ready(rx_ready),
    .ovf_flag(ovf_flag_0), .ovf_clr(ovf_clr), .UART_CSN(csn_0), .UART_WEN(wen_0), .UART_OEN(oen_0),
    .UART_WDATA(wdata_0), .UART_RDATA(rdata), .UART_TXRDY(txrdy), .UART_RXRDY(rxrdy),
    .UART_PERR(perr), .UART_FERR(ferr), .UART_OVF(ovf));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  function automatic acc_t mk(bit wr, logic [7:0] d, logic [1:0] e);
    acc_t a;
    a.wr = wr; a.d = d; a.e = e;
    return a;
  endfunction

  // Monitor at the falling edge: pops expected accesses when a strobe appears, checks captured read data next cycle.
  task automatic sample();
    acc_t a;
    @(negedge clk);
    seen = 0; seen0 = 0;
    if (rd_pend) begin
      rd_pend = 0; total++;
      if ({rx_valid, rx_err, rx_data} !== {1'b1, pend.e, pend.d}) begin
        bad++; $display("FAIL rx_capture: got v=%b err=%b data=%h want v=1 err=%b data=%h", rx_valid, rx_err, rx_data, pend.e, pend.d);
      end
    end
    if (csn === 1'b0) begin
      seen = 1; total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL access_unexpected: got wen=%b oen=%b wdata=%h want no access", wen, oen, wdata);
      end else begin
        a = exp_q.pop_front();
        if ({wen, oen} !== (a.wr ? 2'b01 : 2'b10) || (a.wr && wdata !== a.d)) begin
          bad++; $display("FAIL access: got wen=%b oen=%b wdata=%h want wr=%0d data=%h", wen, oen, wdata, a.wr, a.d);
        end
        if (!a.wr) begin rd_pend = 1; pend = a; end
      end
    end
    if (mon0 && rd_pend0) begin
      rd_pend0 = 0; total++;
      if ({rx_valid_0, rx_err_0, rx_data_0} !== {1'b1, pend0.e, pend0.d}) begin
        bad++; $display("FAIL rx_capture0: got v=%b err=%b data=%h want v=1 err=%b data=%h", rx_valid_0, rx_err_0, rx_data_0, pend0.e, pend0.d);
      end
    end
    if (mon0 && csn_0 === 1'b0) begin
      seen0 = 1; total++;
      if (exp_q0.size() == 0) begin
        bad++; $display("FAIL access_unexpected0: got wen=%b oen=%b want no access", wen_0, oen_0);
      end else begin
        a = exp_q0.pop_front();
        if ({wen_0, oen_0} !== (a.wr ? 2'b01 : 2'b10) || (a.wr && wdata_0 !== a.d)) begin
          bad++; $display("FAIL access0: got wen=%b oen=%b wdata=%h want wr=%0d data=%h", wen_0, oen_0, wdata_0, a.wr, a.d);
        end
        if (!a.wr) begin rd_pend0 = 1; pend0 = a; end
      end
    end
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    sample(); adv();
  endtask

  task automatic do_reset();
    rst = 1; tx_valid = 0; tx_valid0 = 0; rx_ready = 0; ovf_clr = 0;
    rxrdy = 0; txrdy = 0; perr = 0; ferr = 0; ovf = 0;
    exp_q.delete(); exp_q0.delete(); rd_pend = 0; rd_pend0 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    tx_valid = 1; txrdy = 1; rxrdy = 1; tx_data = 8'hFF;
    repeat (2) @(negedge clk);
    total++; if ({csn, wen, oen} !== 3'b111) begin bad++; $display("FAIL reset_strobes: got %b want 111", {csn, wen, oen}); end
    total++; if (wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata: got %h want 00", wdata); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
    total++; if ({rx_valid, rx_err, rx_data} !== 11'h000) begin bad++; $display("FAIL reset_rx: got v=%b err=%b data=%h want 0", rx_valid, rx_err, rx_data); end
    total++; if (ovf_flag !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf_flag); end
    tx_valid = 0; txrdy = 0; rxrdy = 0;
    @(posedge clk); #1 rst = 0;
    repeat (3) tick();
  endtask

  task automatic test_write();
    logic [0:6] want = 7'b1000010;
    tx_data = 8'hA5; tx_valid = 1; txrdy = 1;
    exp_q.push_back(mk(1'b1, 8'hA5, 2'b00));
    for (int i = 0; i < 7; i++) begin
      sample();
      total++; if (tx_ready !== want[i]) begin bad++; $display("FAIL tx_ready_c%0d: got %b want %b", i, tx_ready, want[i]); end
      if (i == 1) begin total++; if (!seen) begin bad++; $display("FAIL write_latency: got no strobe want write strobe"); end end
      adv();
      if (i == 0) begin tx_data = 8'h5A; exp_q.push_back(mk(1'b1, 8'h5A, 2'b00)); end
      if (i == 5) tx_valid = 0;
    end
    total++; if (!seen || exp_q.size() != 0) begin bad++; $display("FAIL write_spacing: got seen=%0d left=%0d want seen=1 left=0", seen, exp_q.size()); end
    repeat (4) tick();
  endtask

  task automatic test_read();
    rxrdy = 1; rdata = 8'h3C;
    exp_q.push_back(mk(1'b0, 8'h3C, 2'b00));
    for (int i = 0; i < 10; i++) begin
      sample();
      if (i == 1) begin total++; if (!seen) begin bad++; $display("FAIL read_latency: got no strobe want read strobe"); end end
      if (i == 9) begin total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rx_hold: got %b want 1", rx_valid); end end
      adv();
    end
    rx_ready = 1; rdata = 8'h77;
    exp_q.push_back(mk(1'b0, 8'h77, 2'b00));
    sample(); adv(); rx_ready = 0;
    sample();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_pop: got %b want 0", rx_valid); end
    adv();
    sample();
    total++; if (!seen) begin bad++; $display("FAIL reread: got no strobe want read strobe"); end
    adv(); rxrdy = 0;
    sample(); adv();
    rx_ready = 1; sample(); adv(); rx_ready = 0;
    repeat (4) tick();
  endtask

  task automatic test_priority();
    logic a, a0;
    do_reset(); mon0 = 1;
    rxrdy = 1; rdata = 8'h11; txrdy = 1; tx_data = 8'h22; tx_valid = 1; tx_valid0 = 1;
    exp_q.push_back(mk(1'b0, 8'h11, 2'b00));  exp_q.push_back(mk(1'b1, 8'h22, 2'b00));
    exp_q0.push_back(mk(1'b1, 8'h22, 2'b00)); exp_q0.push_back(mk(1'b0, 8'h11, 2'b00));
    for (int i = 0; i < 7; i++) begin
      sample();
      a = tx_ready; a0 = tx_ready_0;
      total++; if (a !== (i == 5)) begin bad++; $display("FAIL prio_rd_tx_ready_c%0d: got %b want %b", i, a, (i == 5)); end
      total++; if (a0 !== (i == 0)) begin bad++; $display("FAIL prio_wr_tx_ready_c%0d: got %b want %b", i, a0, (i == 0)); end
      adv();
      if (a) tx_valid = 0;
      if (a0) tx_valid0 = 0;
    end
    total++; if (exp_q.size() != 0 || exp_q0.size() != 0) begin bad++; $display("FAIL prio_order: got left=%0d/%0d want 0/0", exp_q.size(), exp_q0.size()); end
    rxrdy = 0;
    sample(); adv();
    rx_ready = 1; sample(); adv(); rx_ready = 0;
    repeat (5) tick();
    mon0 = 0;
  endtask

  task automatic test_errors();
    int n;
    for (int j = 0; j < 2; j++) begin
      rxrdy = 1; rdata = (j == 0) ? 8'h5E : 8'hE1; perr = (j == 0); ferr = (j == 1);
      exp_q.push_back(mk(1'b0, rdata, (j == 0) ? 2'b01 : 2'b10));
      n = 0; seen = 0;
      while (!seen && n < 20) begin sample(); adv(); n++; end
      total++; if (!seen) begin bad++; $display("FAIL err_read_timeout: got no strobe in %0d cycles want read", n); end
      rxrdy = 0; perr = 0; ferr = 0;
      sample(); adv();
      rx_ready = 1; sample(); adv(); rx_ready = 0;
      repeat (4) tick();
    end
    ovf = 1; sample();
    total++; if (ovf_flag !== 1'b0) begin bad++; $display("FAIL ovf_pre: got %b want 0", ovf_flag); end
    adv(); ovf = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      total++; if (ovf_flag !== 1'b1) begin bad++; $display("FAIL ovf_sticky_c%0d: got %b want 1", i, ovf_flag); end
      adv();
    end
    ovf_clr = 1; adv(); ovf_clr = 0; sample();
    total++; if (ovf_flag !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", ovf_flag); end
    adv();
    ovf = 1; ovf_clr = 1; adv(); ovf = 0; ovf_clr = 0; sample();
    total++; if (ovf_flag !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", ovf_flag); end
    adv();
    ovf_clr = 1; adv(); ovf_clr = 0; sample();
    total++; if (ovf_flag !== 1'b0) begin bad++; $display("FAIL ovf_clear2: got %b want 0", ovf_flag); end
    adv();
  endtask

  task automatic test_back_to_back();
    int k = 0, last = -1, n = 0;
    logic ack;
    tx_valid = 1; tx_data = 8'h81; txrdy = 0;
    repeat (3) begin
      sample();
      total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL tx_ready_no_txrdy: got %b want 0", tx_ready); end
      adv();
    end
    txrdy = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, 8'h81 + 8'(i), 2'b00));
    while (exp_q.size() != 0 && n < 60) begin
      sample();
      if (seen) begin
        if (last >= 0) begin
          total++; if (n - last != 5) begin bad++; $display("FAIL b2b_spacing: got %0d cycles want 5", n - last); end
        end
        last = n;
      end
      ack = tx_ready;
      adv(); n++;
      if (ack) begin
        k++;
        if (k == 4) tx_valid = 0;
        else tx_data = 8'h81 + 8'(k);
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_timeout: got %0d pending want 0", exp_q.size()); end
    tx_valid = 0;
    repeat (5) tick();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    rxrdy = 1; rdata = 8'h99;
    exp_q.push_back(mk(1'b0, 8'h99, 2'b00));
    seen = 0;
    while (!seen && n < 20) begin sample(); adv(); n++; end
    rxrdy = 0;
    sample(); adv();
    repeat (4) tick();
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_rx_valid: got %b want 1", rx_valid); end
    tx_valid = 1; tx_data = 8'hC3; txrdy = 1;
    exp_q.push_back(mk(1'b1, 8'hC3, 2'b00));
    sample(); adv(); tx_valid = 0;
    sample();
    total++; if (!seen) begin bad++; $display("FAIL write_before_reset: got no strobe want write strobe"); end
    rst = 1; tx_valid = 1; tx_data = 8'h3D;
    #1;
    total++; if ({csn, wen, oen} !== 3'b111) begin bad++; $display("FAIL midreset_strobes: got %b want 111", {csn, wen, oen}); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL midreset_tx_ready: got %b want 0", tx_ready); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL midreset_rx_valid: got %b want 0", rx_valid); end
    total++; if (wdata !== 8'h00) begin bad++; $display("FAIL midreset_wdata: got %h want 00", wdata); end
    @(posedge clk); #1 rst = 0;
    exp_q.push_back(mk(1'b1, 8'h3D, 2'b00));
    sample();
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL post_reset_accept: got %b want 1", tx_ready); end
    adv(); tx_valid = 0;
    sample();
    total++; if (!seen) begin bad++; $display("FAIL post_reset_write: got no strobe want write strobe"); end
    adv();
    repeat (4) tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL post_reset_pending: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_priority();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
